// File: rtl/ast_nms_3x3_if.sv
// Corner record stream between the NMS block and its consumer.
// Master drives (x, y, score) with valid; slave answers with ready.
interface ast_nms_3x3_if #(
    parameter int W  = 8,
    parameter int XW = 12
);
    logic          corner_valid;
    logic          corner_ready;
    logic [XW-1:0] corner_x;
    logic [XW-1:0] corner_y;
    logic [W-1:0]  corner_score;

    modport master (
        output corner_valid,
        output corner_x,
        output corner_y,
        output corner_score,
        input  corner_ready
    );

    modport slave (
        input  corner_valid,
        input  corner_x,
        input  corner_y,
        input  corner_score,
        output corner_ready
    );
endinterface

// File: rtl/ast_nms_3x3.sv
// 3x3 non-maximum suppression over the FAST score raster.
// Survivors leave as (x, y, score) records through a small FIFO.
module ast_nms_3x3 #(
    parameter int W       = 8,
    parameter int IMG_W   = 752,
    parameter int XW      = 12,
    parameter int FIFO_LG = 4
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          sof,
    input  logic          dv,
    input  logic          q,
    input  logic [W-1:0]  score,
    ast_nms_3x3_if.master cor,
    output logic [15:0]   frame_corners,
    output logic [15:0]   drop_cnt
);

    localparam int AW    = $clog2(IMG_W);
    localparam int DEPTH = 1 << FIFO_LG;
    localparam int CW    = FIFO_LG + 1;

    localparam logic [XW-1:0] IMG_WX = XW'(IMG_W);
    localparam logic [CW-1:0] FULLC  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ROW
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [W-1:0]  s;
    } rec_t;

    state_t        state_q, state_d;
    logic [XW-1:0] col_q, col_d;
    logic [XW-1:0] row_q, row_d;
    logic          acc;
    logic          clr;

    logic [W-1:0]  s;
    logic [AW-1:0] col_a;
    logic [W-1:0]  up1;
    logic [W-1:0]  up2;

    logic [W-1:0]  lb1 [IMG_W];
    logic [W-1:0]  lb2 [IMG_W];

    logic [W-1:0]  top_q [2];
    logic [W-1:0]  mid_q [2];
    logic [W-1:0]  bot_q [2];

    logic [W-1:0]  ctr;
    logic          gt_early;
    logic          ge_late;
    logic          in_rng;
    logic          hit;
    rec_t          cand;

    logic          d1_v, d2_v;
    rec_t          d1_q, d2_q;

    rec_t          mem [DEPTH];
    logic [FIFO_LG-1:0] wr_q, rd_q, rd_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          full;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          hv_q;
    rec_t          hd_q, hd_n;

    assign s     = q ? score : '0;
    assign col_a = col_q[AW-1:0];
    assign up1   = lb1[col_a];
    assign up2   = lb2[col_a];

    // Frame/row tracking: next state, counters and pixel acceptance.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        acc     = 1'b0;
        clr     = 1'b0;
        if (sof) begin
            state_d = GAP;
            col_d   = '0;
            row_d   = '0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                GAP: begin
                    if (dv) begin
                        state_d = ROW;
                        acc     = col_q < IMG_WX;
                    end
                end
                ROW: begin
                    if (dv) begin
                        acc = col_q < IMG_WX;
                    end else begin
                        state_d = GAP;
                        row_d   = row_q + XW'(1);
                        col_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (acc) begin
                col_d = col_q + XW'(1);
            end
        end
    end

    // State and raster counters.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Line buffers: lb1 holds row-1, lb2 inherits the displaced row-2 entry.
    always_ff @(posedge c) begin
        if (acc) begin
            lb1[col_a] <= s;
            lb2[col_a] <= up1;
        end
    end

    // Window columns col-2 and col-1; column col comes straight from the buffers.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '{default: '0};
            mid_q <= '{default: '0};
            bot_q <= '{default: '0};
        end else if (clr) begin
            top_q <= '{default: '0};
            mid_q <= '{default: '0};
            bot_q <= '{default: '0};
        end else if (acc) begin
            top_q[0] <= top_q[1];
            top_q[1] <= up2;
            mid_q[0] <= mid_q[1];
            mid_q[1] <= up1;
            bot_q[0] <= bot_q[1];
            bot_q[1] <= s;
        end
    end

    // Strict against raster-earlier neighbours, non-strict against later ones,
    // so only the first pixel of an equal plateau survives.
    always_comb begin
        ctr      = mid_q[1];
        gt_early = (ctr > top_q[0]) && (ctr > top_q[1]) &&
                   (ctr > up2) && (ctr > mid_q[0]);
        ge_late  = (ctr >= up1) && (ctr >= bot_q[0]) &&
                   (ctr >= bot_q[1]) && (ctr >= s);
        in_rng   = (col_q >= XW'(2)) && (row_q >= XW'(2));
        hit      = acc && (ctr != '0) && gt_early && ge_late && in_rng;
        cand.x   = col_q - XW'(1);
        cand.y   = row_q - XW'(1);
        cand.s   = ctr;
    end

    // Two-stage decision pipeline ahead of the FIFO write.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            d1_v <= 1'b0;
            d1_q <= '0;
            d2_v <= 1'b0;
            d2_q <= '0;
        end else begin
            d1_v <= hit;
            d1_q <= cand;
            d2_v <= d1_v;
            d2_q <= d1_q;
        end
    end

    assign push    = d2_v;
    assign pop     = hv_q & cor.corner_ready;
    assign full    = cnt_q == FULLC;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    // Next head: a push landing in the slot being exposed bypasses the RAM.
    always_comb begin
        rd_n  = rd_q + FIFO_LG'(pop);
        cnt_n = cnt_q + CW'(push_ok) - CW'(pop);
        hd_n  = mem[rd_n];
        if (push_ok && (wr_q == rd_n)) begin
            hd_n = d2_q;
        end
        if (cnt_n == '0) begin
            hd_n = '0;
        end
    end

    // FIFO storage.
    always_ff @(posedge c) begin
        if (push_ok) begin
            mem[wr_q] <= d2_q;
        end
    end

    // FIFO pointers and registered head.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            hv_q  <= 1'b0;
            hd_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + FIFO_LG'(1);
            end
            rd_q  <= rd_n;
            cnt_q <= cnt_n;
            hv_q  <= cnt_n != '0;
            hd_q  <= hd_n;
        end
    end

    // Saturating per-frame push count and lifetime drop count.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            frame_corners <= '0;
            drop_cnt      <= '0;
        end else begin
            if (sof) begin
                frame_corners <= '0;
            end else if (push_ok && (frame_corners != 16'hFFFF)) begin
                frame_corners <= frame_corners + 16'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign cor.corner_valid = hv_q;
    assign cor.corner_x     = hd_q.x;
    assign cor.corner_y     = hd_q.y;
    assign cor.corner_score = hd_q.s;

endmodule

// File: tb/tb_ast_nms_3x3.sv
// Directed bench for ast_nms_3x3 on an 8-pixel-wide image.
// Expected records are hand-placed corners with known survivors.
module tb_ast_nms_3x3;

    localparam int W  = 8;
    localparam int XW = 12;
    localparam int IW = 8;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        dv = 1'b0;
    logic        q = 1'b0;
    logic [W-1:0] score = '0;
    logic [15:0] frame_corners;
    logic [15:0] drop_cnt;

    ast_nms_3x3_if #(.W(W), .XW(XW)) cif ();

    ast_nms_3x3 #(
        .W(W),
        .IMG_W(IW),
        .XW(XW),
        .FIFO_LG(4)
    ) dut (
        .c(c),
        .rst_n(rst_n),
        .sof(sof),
        .dv(dv),
        .q(q),
        .score(score),
        .cor(cif),
        .frame_corners(frame_corners),
        .drop_cnt(drop_cnt)
    );

    always #5 c = ~c;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = -1;
    int fv_cyc = -1;

    logic [7:0]  img [16][IW];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    // Cycle counter.
    always @(posedge c) cyc <= cyc + 1;

    // Capture every accepted record.
    always @(posedge c) begin
        if (rst_n && cif.corner_valid && cif.corner_ready)
            got_q.push_back({cif.corner_x, cif.corner_y,
                             cif.corner_score});
    end

    // First cycle at which a record shows up.
    always @(negedge c) begin
        if (cif.corner_valid && fv_cyc < 0)
            fv_cyc = cyc;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    function automatic logic [31:0] rec(input int i);
        if (got_q.size() > i) return got_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] mk(input int x, input int y,
                                       input int s);
        return {12'(x), 12'(y), 8'(s)};
    endfunction

    task automatic clr_img();
        for (int r = 0; r < 16; r++)
            for (int x = 0; x < IW; x++)
                img[r][x] = 8'h00;
    endtask

    task automatic run_frame(input int nrows,
                             input int rst_r,
                             input int rst_c);
        @(negedge c);
        sof = 1'b1;
        @(negedge c);
        sof = 1'b0;
        chk("fc_sof", 64'(frame_corners), 64'd0);
        @(negedge c);
        for (int r = 0; r < nrows; r++) begin
            for (int x = 0; x < IW; x++) begin
                if (r == rst_r && x == rst_c) begin
                    dv = 1'b0;
                    chk("pre_rst_v", 64'(cif.corner_valid), 64'd1);
                    chk("pre_rst_fc", 64'(frame_corners), 64'd1);
                    rst_n = 1'b0;
                    #1;
                    chk("rst_v", 64'(cif.corner_valid), 64'd0);
                    chk("rst_x", 64'(cif.corner_x), 64'd0);
                    chk("rst_y", 64'(cif.corner_y), 64'd0);
                    chk("rst_s", 64'(cif.corner_score), 64'd0);
                    chk("rst_fc", 64'(frame_corners), 64'd0);
                    chk("rst_drop", 64'(drop_cnt), 64'd0);
                    @(negedge c);
                    rst_n = 1'b1;
                end
                dv = 1'b1;
                q = img[r][x] != 8'h00;
                score = q ? img[r][x] : 8'hEE;
                if (r == 3 && x == 4) acc_cyc = cyc;
                @(negedge c);
            end
            dv = 1'b0;
            q = 1'b0;
            score = '0;
            @(negedge c);
            @(negedge c);
        end
        repeat (6) @(negedge c);
    endtask

    initial begin
        int k;
        cif.corner_ready = 1'b0;
        repeat (3) @(negedge c);
        chk("rst0_v", 64'(cif.corner_valid), 64'd0);
        chk("rst0_x", 64'(cif.corner_x), 64'd0);
        chk("rst0_s", 64'(cif.corner_score), 64'd0);
        chk("rst0_fc", 64'(frame_corners), 64'd0);
        chk("rst0_drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge c);

        // single isolated corner
        cif.corner_ready = 1'b1;
        clr_img();
        img[2][3] = 8'h50;
        got_q.delete();
        fv_cyc = -1;
        run_frame(5, -1, -1);
        chk("t1_n", 64'(got_q.size()), 64'd1);
        chk("t1_rec", 64'(rec(0)), 64'(mk(3, 2, 8'h50)));
        chk("t1_lat", 64'(fv_cyc), 64'(acc_cyc + 3));
        chk("t1_fc", 64'(frame_corners), 64'd1);

        // equal plateau keeps the first pixel
        clr_img();
        img[2][3] = 8'h30;
        img[2][4] = 8'h30;
        got_q.delete();
        run_frame(5, -1, -1);
        chk("t2a_n", 64'(got_q.size()), 64'd1);
        chk("t2a_rec", 64'(rec(0)), 64'(mk(3, 2, 8'h30)));

        // larger right neighbour wins
        img[2][4] = 8'h31;
        got_q.delete();
        run_frame(5, -1, -1);
        chk("t2b_n", 64'(got_q.size()), 64'd1);
        chk("t2b_rec", 64'(rec(0)), 64'(mk(4, 2, 8'h31)));
        chk("t2b_fc", 64'(frame_corners), 64'd1);

        // border corners never emitted
        clr_img();
        img[2][0] = 8'h70;
        img[2][7] = 8'h70;
        img[0][3] = 8'h70;
        got_q.delete();
        run_frame(5, -1, -1);
        chk("t3_n", 64'(got_q.size()), 64'd0);
        chk("t3_drop", 64'(drop_cnt), 64'd0);
        chk("t3_fc", 64'(frame_corners), 64'd0);

        // 20 isolated corners into a stalled 16-deep FIFO
        cif.corner_ready = 1'b0;
        clr_img();
        exp_q.delete();
        k = 0;
        for (int y = 1; y <= 13; y += 2)
            for (int x = 1; x <= 5; x += 2)
                if (k < 20) begin
                    k++;
                    img[y][x] = 8'(k);
                    exp_q.push_back(mk(x, y, k));
                end
        got_q.delete();
        run_frame(15, -1, -1);
        chk("t4_v", 64'(cif.corner_valid), 64'd1);
        chk("t4_hx", 64'(cif.corner_x), 64'd1);
        chk("t4_hy", 64'(cif.corner_y), 64'd1);
        chk("t4_hs", 64'(cif.corner_score), 64'd1);
        chk("t4_drop", 64'(drop_cnt), 64'd4);
        chk("t4_fc", 64'(frame_corners), 64'd16);
        cif.corner_ready = 1'b1;
        repeat (25) @(negedge c);
        chk("t4_n", 64'(got_q.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t4_rec%0d", i),
                64'(rec(i)), 64'(exp_q[i]));
        chk("t4_empty", 64'(cif.corner_valid), 64'd0);

        // reset mid-row 3 with a record waiting
        cif.corner_ready = 1'b0;
        clr_img();
        img[2][3] = 8'h50;
        got_q.delete();
        run_frame(5, 3, 7);
        cif.corner_ready = 1'b1;
        repeat (10) @(negedge c);
        chk("t5_n", 64'(got_q.size()), 64'd0);
        chk("t5_fc", 64'(frame_corners), 64'd0);
        fv_cyc = -1;
        run_frame(5, -1, -1);
        chk("t5r_n", 64'(got_q.size()), 64'd1);
        chk("t5r_rec", 64'(rec(0)), 64'(mk(3, 2, 8'h50)));
        chk("t5r_lat", 64'(fv_cyc), 64'(acc_cyc + 3));
        chk("t5r_fc", 64'(frame_corners), 64'd1);

        // sof after row 2: row restarts, queued record survives
        cif.corner_ready = 1'b0;
        clr_img();
        img[1][3] = 8'h40;
        got_q.delete();
        run_frame(3, -1, -1);
        chk("t6_fc0", 64'(frame_corners), 64'd1);
        chk("t6_v", 64'(cif.corner_valid), 64'd1);
        clr_img();
        img[2][3] = 8'h50;
        run_frame(5, -1, -1);
        chk("t6_fc1", 64'(frame_corners), 64'd1);
        cif.corner_ready = 1'b1;
        repeat (10) @(negedge c);
        chk("t6_n", 64'(got_q.size()), 64'd2);
        chk("t6_rec0", 64'(rec(0)), 64'(mk(3, 1, 8'h40)));
        chk("t6_rec1", 64'(rec(1)), 64'(mk(3, 2, 8'h50)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
